// File: rtl/topo_sort_sequencer.sv
// topo_sort_sequencer: Kahn's-algorithm driver for the in-degree table.
// Seeds a ready FIFO with every zero-in-degree node, then pops nodes in FIFO
// order, streams each one out, fetches its successor list and decrements
// every successor, pushing any successor whose degree reaches zero.
// All outputs are registered: each one is computed from the next state.
// Optional feature: define TOPO_CYCLE_DETECT_EN to add the cycle_error output.
module topo_sort_sequencer #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NODE_WIDTH:0]   node_count,
    output logic [NODE_WIDTH-1:0] node_sel,
    output logic                  decrement_degree,
    input  logic [NODE_WIDTH-1:0] node_degree,
    output logic                  adj_req_valid,
    input  logic                  adj_req_ready,
    output logic [NODE_WIDTH-1:0] adj_req_node,
    input  logic                  adj_succ_valid,
    output logic                  adj_succ_ready,
    input  logic [NODE_WIDTH-1:0] adj_succ_node,
    input  logic                  adj_succ_last,
    input  logic                  adj_succ_empty,
    output logic                  sorted_valid,
    input  logic                  sorted_ready,
    output logic [NODE_WIDTH-1:0] sorted_node,
    output logic                  busy,
    output logic                  done,
`ifdef TOPO_CYCLE_DETECT_EN
    output logic                  cycle_error,
`endif
    output logic [NODE_WIDTH:0]   sorted_count
);

    localparam int CNT_W = NODE_WIDTH + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_SCAN_TAIL,
        S_POP,
        S_EMIT,
        S_REQ,
        S_SUCC,
        S_DEC,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [NODE_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic [NODE_WIDTH-1:0] cur_q, cur_d;
    logic [NODE_WIDTH-1:0] succ_q, succ_d;
    logic                  last_q, last_d;
    logic [NODE_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [NODE_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]      sorted_count_q, sorted_count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NODE_WIDTH-1:0] node_sel_q, node_sel_d;
    logic                  dec_q, dec_d;
    logic                  adj_req_valid_q, adj_req_valid_d;
    logic [NODE_WIDTH-1:0] adj_req_node_q, adj_req_node_d;
    logic                  adj_succ_ready_q, adj_succ_ready_d;
    logic                  sorted_valid_q, sorted_valid_d;
    logic [NODE_WIDTH-1:0] sorted_node_q, sorted_node_d;
`ifdef TOPO_CYCLE_DETECT_EN
    logic                  cycle_err_q, cycle_err_d;
`endif

    // Ready FIFO: each node enters at most once, so MAX_NODES entries suffice.
    logic [NODE_WIDTH-1:0] fifo_mem [MAX_NODES];
    logic                  push_en;
    logic [NODE_WIDTH-1:0] push_node;
    logic                  do_push;
    logic                  pop_en;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign fifo_full  = (fifo_cnt_q == CNT_W'(MAX_NODES));
    assign fifo_empty = (fifo_cnt_q == '0);

    function automatic logic [NODE_WIDTH-1:0] ptr_inc(input logic [NODE_WIDTH-1:0] p);
        return (p == NODE_WIDTH'(MAX_NODES - 1)) ? '0 : p + NODE_WIDTH'(1);
    endfunction

    // Next-state, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        scan_idx_d     = scan_idx_q;
        cur_d          = cur_q;
        succ_d         = succ_q;
        last_d         = last_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fifo_cnt_d     = fifo_cnt_q;
        sorted_count_d = sorted_count_q;
        done_d         = done_q;
`ifdef TOPO_CYCLE_DETECT_EN
        cycle_err_d    = cycle_err_q;
`endif
        push_en        = 1'b0;
        push_node      = '0;
        pop_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d            = node_count;
                    done_d         = 1'b0;
                    sorted_count_d = '0;
`ifdef TOPO_CYCLE_DETECT_EN
                    cycle_err_d    = 1'b0;
`endif
                    scan_idx_d     = '0;
                    wr_ptr_d       = '0;
                    rd_ptr_d       = '0;
                    fifo_cnt_d     = '0;
                    state_d        = (node_count == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                // node_degree now answers the address issued last cycle
                if ((scan_idx_q != '0) && (node_degree == '0)) begin
                    push_en   = 1'b1;
                    push_node = scan_idx_q - NODE_WIDTH'(1);
                end
                if ({1'b0, scan_idx_q} == (n_q - CNT_W'(1))) begin
                    state_d = S_SCAN_TAIL;
                end else begin
                    scan_idx_d = scan_idx_q + NODE_WIDTH'(1);
                end
            end
            S_SCAN_TAIL: begin
                if (node_degree == '0) begin
                    push_en   = 1'b1;
                    push_node = scan_idx_q;
                end
                state_d = S_POP;
            end
            S_POP: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end else begin
                    pop_en  = 1'b1;
                    cur_d   = fifo_mem[rd_ptr_q];
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (sorted_ready) begin
                    sorted_count_d = sorted_count_q + CNT_W'(1);
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                if (adj_req_ready) begin
                    state_d = S_SUCC;
                end
            end
            S_SUCC: begin
                if (adj_succ_valid) begin
                    succ_d  = adj_succ_node;
                    last_d  = adj_succ_last;
                    state_d = adj_succ_empty ? S_POP : S_DEC;
                end
            end
            S_DEC: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // node_degree is the post-decrement value of succ
                if (node_degree == '0) begin
                    push_en   = 1'b1;
                    push_node = succ_q;
                end
                state_d = last_q ? S_POP : S_SUCC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A push into a full FIFO is silently dropped
        do_push = push_en && !fifo_full;
        if (do_push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            fifo_cnt_d = fifo_cnt_d + CNT_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            fifo_cnt_d = fifo_cnt_d - CNT_W'(1);
        end

        // Outputs follow the state being entered
        node_sel_d = '0;
        dec_d      = 1'b0;
        if (state_d == S_SCAN) begin
            node_sel_d = scan_idx_d;
        end else if (state_d == S_DEC) begin
            node_sel_d = succ_d;
            dec_d      = 1'b1;
        end
        adj_req_valid_d  = (state_d == S_REQ);
        adj_req_node_d   = cur_d;
        adj_succ_ready_d = (state_d == S_SUCC);
        sorted_valid_d   = (state_d == S_EMIT);
        sorted_node_d    = cur_d;
        busy_d           = !((state_d == S_IDLE) || (state_d == S_DONE));
        if (state_d == S_DONE) begin
            done_d      = 1'b1;
`ifdef TOPO_CYCLE_DETECT_EN
            cycle_err_d = (sorted_count_d != n_d);
`endif
        end
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            n_q              <= '0;
            scan_idx_q       <= '0;
            cur_q            <= '0;
            succ_q           <= '0;
            last_q           <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_cnt_q       <= '0;
            sorted_count_q   <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            node_sel_q       <= '0;
            dec_q            <= 1'b0;
            adj_req_valid_q  <= 1'b0;
            adj_req_node_q   <= '0;
            adj_succ_ready_q <= 1'b0;
            sorted_valid_q   <= 1'b0;
            sorted_node_q    <= '0;
`ifdef TOPO_CYCLE_DETECT_EN
            cycle_err_q      <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            n_q              <= n_d;
            scan_idx_q       <= scan_idx_d;
            cur_q            <= cur_d;
            succ_q           <= succ_d;
            last_q           <= last_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fifo_cnt_q       <= fifo_cnt_d;
            sorted_count_q   <= sorted_count_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            node_sel_q       <= node_sel_d;
            dec_q            <= dec_d;
            adj_req_valid_q  <= adj_req_valid_d;
            adj_req_node_q   <= adj_req_node_d;
            adj_succ_ready_q <= adj_succ_ready_d;
            sorted_valid_q   <= sorted_valid_d;
            sorted_node_q    <= sorted_node_d;
`ifdef TOPO_CYCLE_DETECT_EN
            cycle_err_q      <= cycle_err_d;
`endif
        end
    end

    // FIFO storage write port; contents need no reset since pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_node;
        end
    end

    assign node_sel         = node_sel_q;
    assign decrement_degree = dec_q;
    assign adj_req_valid    = adj_req_valid_q;
    assign adj_req_node     = adj_req_node_q;
    assign adj_succ_ready   = adj_succ_ready_q;
    assign sorted_valid     = sorted_valid_q;
    assign sorted_node      = sorted_node_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign sorted_count     = sorted_count_q;
`ifdef TOPO_CYCLE_DETECT_EN
    assign cycle_error      = cycle_err_q;
`endif

endmodule

// File: doc/topo_sort_sequencer.md
Name: topo_sort_sequencer

Overview:
- Kahn's-algorithm driver for the in-degree table.
- Initiator side of the table's update interface: drives node_sel/decrement_degree, consumes node_degree.
- Seeds a ready queue with zero-in-degree nodes, then repeatedly pops a node, emits it on the sorted stream, fetches its successors from an adjacency reader, and decrements each successor.
- Sits between edge loading (table fully built) and the path-count accumulation stage.

Parameters:
- MAX_NODES, 1024, node capacity; also the ready-FIFO depth, since each node is pushed at most once.
- NODE_WIDTH, $clog2(MAX_NODES), node id and degree width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins sort; ignored while busy
- node_count  in  NODE_WIDTH+1  number of nodes (ids 0..node_count-1); sampled at start
- node_sel  out  NODE_WIDTH  table address
- decrement_degree  out  1  decrement request for node_sel
- node_degree  in  NODE_WIDTH  table read data, one cycle after node_sel; post-decrement when decrementing
- adj_req_valid  out  1  successor-list request
- adj_req_ready  in  1
- adj_req_node  out  NODE_WIDTH  node whose successors are requested
- adj_succ_valid  in  1  successor beat
- adj_succ_ready  out  1
- adj_succ_node  in  NODE_WIDTH
- adj_succ_last  in  1  final beat of the list
- adj_succ_empty  in  1  beat carries no successor; must come with adj_succ_last=1
- sorted_valid  out  1  sorted node stream
- sorted_ready  in  1
- sorted_node  out  NODE_WIDTH
- busy  out  1
- done  out  1  held high from completion until next start
- sorted_count  out  NODE_WIDTH+1  nodes emitted in this run

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, sorted_count 0. The table is not cleared by this block.
- Reset mid-run aborts immediately and returns to IDLE; no partial output is replayed.
- IDLE: on start, latch node_count, clear done and sorted_count, set busy, go to SCAN. If node_count==0, go straight to DONE.
- SCAN: one node per cycle, node_sel=i, decrement_degree=0.
  - In cycle i+1, if node_degree==0, push i.
  - After the last issue, go to SCAN_TAIL for one cycle to check node node_count-1, then go to POP.
- POP: if the FIFO is empty, go to DONE. Otherwise pop the head into cur and go to EMIT.
- EMIT: sorted_valid=1, sorted_node=cur. On handshake, sorted_count++ and go to REQ.
- REQ: adj_req_valid=1, adj_req_node=cur. On handshake, go to SUCC.
- SUCC: adj_succ_ready=1. On handshake, register node and last.
  - If empty, go to POP.
  - Otherwise go to DEC.
- DEC: node_sel=succ, decrement_degree=1, then go to CHECK.
- CHECK: if node_degree==0, push succ. If last, go to POP; otherwise go to SUCC.
- Pacing: exactly 3 cycles per successor minimum. A decrement is never issued in consecutive cycles, so the table's read-modify-write completes before any re-read of the same node.
- Idle drive: node_sel=0 and decrement_degree=0 in every state except SCAN/DEC.
- DONE: busy=0, done=1, return to IDLE.
- valid outputs stay stable until their handshake completes; data is never changed while valid is high and ready is low.
- FIFO overflow is impossible for a well-formed DAG. A push when full is dropped and no count changes.
- Caller must not load edges while busy.

Optional Feature:
- Macro: TOPO_CYCLE_DETECT_EN.
- Defined: adds output cycle_error (1 bit, reset 0). Asserted together with done when sorted_count != latched node_count, i.e. the graph contains a cycle. Cleared on start.
- Undefined: port absent; no comparison logic.

Test Plan:
- Chain 0->1->2, node_count=3, degrees {0,1,1}, sorted_ready=1 -> sorted stream 0,1,2; done; sorted_count=3; exactly 2 decrements issued, never in adjacent cycles.
- Diamond 0->{1,2}, 1->3, 2->3 -> order 0,1,2,3; node 3 pushed only after its second decrement returns 0; sorted_count=4.
- Four isolated nodes, every adjacency response adj_succ_empty=1/last=1 -> output 0,1,2,3; no decrement_degree pulses.
- Cycle 0->1->2->1 (with TOPO_CYCLE_DETECT_EN) -> only 0 emitted; done with sorted_count=1; cycle_error=1.
- Random backpressure on sorted_ready and adj_req_ready, plus adj_succ_valid gaps, on the diamond -> identical order, stable data under stall.
- start pulsed while busy -> ignored. rst_n low mid-SUCC -> all outputs 0, IDLE; a fresh start on the rebuilt table sorts correctly.
